prbs_multi_checker: RTL and testbench
=====================================

// Module: prbs_multi_checker
// PURPOSE
//  Parametrised self-synchronising PRBS checker for one SerDes lane RX datapath (rx_data_o slice, rx_pcs_clkout domain).
//  Runtime-selectable PRBS7/15/23/31 and a configurable word width, with a lock state machine.
//  Provides a saturating bit-error counter and a per-word error flag for board-level BER / link bring-up tests.
// PARAMETERS
//  WIDTH      8   data word width in bits, 1..64
//  CNT_W      32  bit-error counter width, >= 4
//  LOCK_CNT   16  consecutive clean words required to enter LOCKED, >= 1
//  UNLOCK_ERR 4   consecutive errored words in LOCKED that force HUNT, >= 1
// PORTS
//  clk_i      in   1        lane RX PCS clock
//  rstn_i     in   1        async active-low reset
//  en_i       in   1        data_i valid this cycle; low = hold all state
//  mode_i     in   2        0:PRBS7 x^7+x^6+1  1:PRBS15 x^15+x^14+1  2:PRBS23 x^23+x^18+1  3:PRBS31 x^31+x^28+1
//  data_i     in   WIDTH    received word; bit 0 is earliest in time
//  clr_i      in   1        sync clear of err_cnt_o
//  lock_o     out  1        1 = state LOCKED
//  err_o      out  1        pulse: word checked in LOCKED had >= 1 bit error
//  err_cnt_o  out  CNT_W    saturating count of bit errors seen while LOCKED
// BEHAVIOUR
//  Clock and reset:
//  - One clock. Reset is asynchronous and active-low.
//  - Reset values: lock_o=0, err_o=0, err_cnt_o=0, 31-bit history=0, state=HUNT, good/bad counters=0.
//  Per-bit prediction:
//  - Input bit n is predicted as e[n]=r[n-A]^r[n-B], with (A,B) = (7,6), (15,14), (23,18), (31,28) per mode.
//  - Bits earlier than the current word are taken from the history register (the last 31 received bits).
//  - Bits within the current word are taken from data_i itself.
//  - err_vec[n] = r[n]^e[n]. nerr = popcount(err_vec), which is at most WIDTH.
//  Word classification:
//  - clean: nerr==0 AND at least one 1 in {history, data_i}. This rejects all-zero lockup.
//  - errored: otherwise.
//  - On en_i=1 the history shifts in data_i, and the FSM and counters update. On en_i=0 nothing changes, and err_o=0.
//  - All outputs are registered. Latency is 1 cycle from the data_i word to lock_o, err_o and err_cnt_o.
//  FSM HUNT:
//  - good_cnt increments on each clean word. An errored word resets it to 0.
//  - When good_cnt reaches LOCK_CNT, go to LOCKED; lock_o=1 on the next edge.
//  FSM LOCKED:
//  - On an errored word: err_o=1, err_cnt_o += nerr (saturates at 2^CNT_W-1, never wraps), bad_cnt++.
//  - On a clean word: bad_cnt=0.
//  - When bad_cnt reaches UNLOCK_ERR, go to HUNT; lock_o=0 on the next edge and good_cnt=0.
//  - The word that causes the unlock is still counted.
//  Mode change:
//  - A change in mode_i (registered compare) forces HUNT on the next cycle and clears good_cnt and bad_cnt.
//  - err_cnt_o is held. History is retained; the lock hunt tolerates the mixed history.
//  Clear:
//  - clr_i=1 sets err_cnt_o=0 next cycle, regardless of en_i.
//  - If clr_i coincides with an increment, the clear wins.
//  - clr_i does not affect the FSM.
//  Errors in HUNT do not touch err_cnt_o or err_o.
// TESTING
//  T1 Clean lock:
//    WIDTH=8, LOCK_CNT=16, PRBS7 stream, en_i=1 continuous.
//    -> lock_o=1 within 18 cycles; err_o never 1; err_cnt_o stays 0.
//  T2 Single-bit error:
//    Locked PRBS7; flip one bit of one word.
//    -> err_o pulses for 1 or 2 words; err_cnt_o +3 (self-sync 2-tap triple); lock_o stays 1.
//  T3 Unlock:
//    UNLOCK_ERR=4; invert 4 consecutive words.
//    -> lock_o falls 1 cycle after the 4th; good stream resumes; lock_o returns within 18 words.
//  T4 All-zero input:
//    data_i=0 for 1000 words in every mode.
//    -> lock_o remains 0; err_cnt_o=0.
//  T5 Saturation and clear:
//    CNT_W=4; locked; one bit flip every 8 words.
//    -> err_cnt_o goes 3, 6, 9, 12, 15 then holds 15.
//    -> clr_i asserted together with a flip gives err_cnt_o=0.
//  T6 Mode switch and reset:
//    Locked PRBS7; switch mode_i to 3 with PRBS31 data and WIDTH=32.
//    -> lock_o=0 next cycle, relocks; err_cnt_o unchanged.
//    -> Async rstn_i low mid-lock clears all outputs immediately.

Source files
------------

// File: rtl/prbs_multi_checker_if.sv
// Lane RX checker bus: received word plus control in, lock/error status out.
interface prbs_multi_checker_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 32
);
    logic             en_i;
    logic [1:0]       mode_i;
    logic [WIDTH-1:0] data_i;
    logic             clr_i;
    logic             lock_o;
    logic             err_o;
    logic [CNT_W-1:0] err_cnt_o;

    modport master (
        output en_i, mode_i, data_i, clr_i,
        input  lock_o, err_o, err_cnt_o
    );

    modport slave (
        input  en_i, mode_i, data_i, clr_i,
        output lock_o, err_o, err_cnt_o
    );
endinterface

// File: rtl/prbs_multi_checker.sv
// Self-synchronising PRBS7/15/23/31 checker for one SerDes RX lane.
// Each received bit is predicted from two earlier received bits, so the
// checker needs no seed; a lock FSM decides when the error count is trusted.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_HUNT   | counting consecutive clean words, errors not recorded
//   ST_LOCKED | stream aligned; errored words counted, may fall to HUNT
module prbs_multi_checker #(
    parameter int WIDTH      = 8,
    parameter int CNT_W      = 32,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_ERR = 4
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    prbs_multi_checker_if.slave  bus
);
    localparam logic [0:0] ST_HUNT   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam int NERR_W = $clog2(WIDTH + 1);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W  = $clog2(UNLOCK_ERR + 1);
    // Headroom so a full word of errors on top of a saturated count cannot wrap.
    localparam int SUM_W  = CNT_W + 8;

    logic [30:0]       hist_q, hist_d;
    logic [1:0]        mode_q, mode_d;
    logic [0:0]        state_q, state_d;
    logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
    logic [BAD_W-1:0]  bad_cnt_q, bad_cnt_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

    // ext[30:0] is history (oldest at 0), ext[31+n] is data_i[n].
    logic [WIDTH+30:0] ext;
    logic [WIDTH-1:0]  err_vec;
    logic [NERR_W-1:0] nerr;
    logic              pred;
    logic              clean;
    logic              mode_chg;
    logic [GOOD_W-1:0] good_inc;
    logic [BAD_W-1:0]  bad_inc;
    logic [SUM_W-1:0]  sum;

    assign ext      = {bus.data_i, hist_q};
    assign mode_chg = (bus.mode_i != mode_q);

    // Per-bit prediction from the selected taps and error popcount.
    always_comb begin
        err_vec = '0;
        nerr    = '0;
        pred    = 1'b0;
        for (int n = 0; n < WIDTH; n++) begin
            case (bus.mode_i)
                2'd0:    pred = ext[31+n-7]  ^ ext[31+n-6];
                2'd1:    pred = ext[31+n-15] ^ ext[31+n-14];
                2'd2:    pred = ext[31+n-23] ^ ext[31+n-18];
                default: pred = ext[31+n-31] ^ ext[31+n-28];
            endcase
            err_vec[n] = ext[31+n] ^ pred;
            nerr       = nerr + NERR_W'(err_vec[n]);
        end
        // An all-zero window satisfies every recurrence, so it never counts as clean.
        clean = (nerr == '0) && (|ext);
    end

    // Lock FSM, history shift and saturating error counter.
    always_comb begin
        hist_d     = hist_q;
        mode_d     = mode_q;
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        err_d      = 1'b0;
        err_cnt_d  = err_cnt_q;
        good_inc   = good_cnt_q + GOOD_W'(1);
        bad_inc    = bad_cnt_q + BAD_W'(1);
        sum        = SUM_W'(err_cnt_q) + SUM_W'(nerr);

        if (bus.en_i) begin
            hist_d = ext[WIDTH+30:WIDTH];
            mode_d = bus.mode_i;
            if (mode_chg) begin
                // Word compared against the old taps' history is not trusted.
                state_d    = ST_HUNT;
                good_cnt_d = '0;
                bad_cnt_d  = '0;
            end else if (state_q == ST_HUNT) begin
                if (clean) begin
                    if (good_inc == GOOD_W'(LOCK_CNT)) begin
                        state_d    = ST_LOCKED;
                        good_cnt_d = '0;
                        bad_cnt_d  = '0;
                    end else begin
                        good_cnt_d = good_inc;
                    end
                end else begin
                    good_cnt_d = '0;
                end
            end else begin
                if (clean) begin
                    bad_cnt_d = '0;
                end else begin
                    err_d = 1'b1;
                    if (sum[SUM_W-1:CNT_W] != '0) begin
                        err_cnt_d = '1;
                    end else begin
                        err_cnt_d = sum[CNT_W-1:0];
                    end
                    if (bad_inc == BAD_W'(UNLOCK_ERR)) begin
                        state_d    = ST_HUNT;
                        good_cnt_d = '0;
                        bad_cnt_d  = '0;
                    end else begin
                        bad_cnt_d = bad_inc;
                    end
                end
            end
        end

        if (bus.clr_i) begin
            err_cnt_d = '0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            hist_q     <= '0;
            mode_q     <= 2'd0;
            state_q    <= ST_HUNT;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            hist_q     <= hist_d;
            mode_q     <= mode_d;
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.lock_o    = (state_q == ST_LOCKED);
    assign bus.err_o     = err_q;
    assign bus.err_cnt_o = err_cnt_q;
endmodule

// File: tb/tb_prbs_multi_checker.sv
// Bench for prbs_multi_checker: a bit-stream model of the lane checks every
// cycle, and directed scenarios pin lock, error and saturation behaviour.
module tb_prbs_multi_checker;
    localparam int W    = 8;
    localparam int CW   = 4;
    localparam int LOCK = 16;
    localparam int UNL  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk_i  = 1'b0;
    logic rstn_i = 1'b0;

    prbs_multi_checker_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    prbs_multi_checker #(
        .WIDTH(W), .CNT_W(CW), .LOCK_CNT(LOCK), .UNLOCK_ERR(UNL)
    ) dut (
        .clk_i (clk_i),
        .rstn_i(rstn_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: the received bit stream plus lock bookkeeping.
    bit         mhist[$];
    logic [1:0] m_mode;
    bit         m_locked;
    int         m_good, m_bad;
    int         exp_lock, exp_err, exp_cnt;

    // Pattern generator state.
    bit         gq[$];
    logic [1:0] cur_mode = 2'd0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic void taps(input logic [1:0] m, output int a, output int b);
        case (m)
            2'd0:    begin a = 7;  b = 6;  end
            2'd1:    begin a = 15; b = 14; end
            2'd2:    begin a = 23; b = 18; end
            default: begin a = 31; b = 28; end
        endcase
    endfunction

    task automatic model_reset();
        mhist.delete();
        for (int i = 0; i < 31; i++) mhist.push_back(1'b0);
        m_mode   = 2'd0;
        m_locked = 1'b0;
        m_good   = 0;
        m_bad    = 0;
        exp_lock = 0;
        exp_err  = 0;
        exp_cnt  = 0;
    endtask

    task automatic model_step(input logic en, input logic [1:0] mode,
                              input logic [W-1:0] d, input logic clr);
        int a, b, k, nerr, add;
        bit anyone, clean;
        nerr = 0; add = 0; anyone = 0;
        exp_err = 0;
        if (en) begin
            taps(mode, a, b);
            foreach (mhist[i]) anyone |= mhist[i];
            for (int n = 0; n < W; n++) begin
                mhist.push_back(d[n]);
                k = mhist.size() - 1;
                if (mhist[k] != (mhist[k-a] ^ mhist[k-b])) nerr++;
                anyone |= d[n];
            end
            while (mhist.size() > 31) void'(mhist.pop_front());
            clean = (nerr == 0) && anyone;
            if (mode != m_mode) begin
                m_locked = 0; m_good = 0; m_bad = 0;
            end else if (!m_locked) begin
                m_good = clean ? m_good + 1 : 0;
                if (m_good == LOCK) begin
                    m_locked = 1; m_good = 0; m_bad = 0;
                end
            end else if (clean) begin
                m_bad = 0;
            end else begin
                exp_err = 1;
                add     = nerr;
                m_bad++;
                if (m_bad == UNL) begin
                    m_locked = 0; m_good = 0; m_bad = 0;
                end
            end
            m_mode = mode;
        end
        exp_cnt  = clr ? 0 : ((exp_cnt + add > CMAX) ? CMAX : exp_cnt + add);
        exp_lock = m_locked;
    endtask

    task automatic seed_gen();
        gq.delete();
        for (int i = 0; i < 31; i++) gq.push_back(bit'($urandom_range(0, 1)));
        gq[30] = 1'b1;
    endtask

    task automatic gen_word(output logic [W-1:0] w);
        int a, b;
        bit nb;
        taps(cur_mode, a, b);
        w = '0;
        for (int n = 0; n < W; n++) begin
            nb = gq[gq.size()-a] ^ gq[gq.size()-b];
            gq.push_back(nb);
            w[n] = nb;
        end
        while (gq.size() > 31) void'(gq.pop_front());
    endtask

    task automatic tick(input logic en, input logic [W-1:0] d, input logic clr);
        bus.en_i   = en;
        bus.data_i = d;
        bus.clr_i  = clr;
        bus.mode_i = cur_mode;
        @(posedge clk_i);
        if (rstn_i) model_step(en, cur_mode, d, clr);
        #1;
    endtask

    task automatic good_words(input int n);
        logic [W-1:0] w;
        for (int i = 0; i < n; i++) begin
            gen_word(w);
            tick(1'b1, w, 1'b0);
        end
    endtask

    task automatic do_reset();
        rstn_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
    endtask

    // Every cycle: DUT outputs against the model.
    always @(negedge clk_i) begin
        chk("lock_o", int'(bus.lock_o), exp_lock);
        chk("err_o", int'(bus.err_o), exp_err);
        chk("err_cnt_o", int'(bus.err_cnt_o), exp_cnt);
    end

    initial begin
        logic [W-1:0] w;
        int pulses, seen_lock;

        bus.en_i = 1'b0; bus.mode_i = 2'd0; bus.data_i = '0; bus.clr_i = 1'b0;
        do_reset();
        chk("reset lock", int'(bus.lock_o), 0);
        chk("reset err", int'(bus.err_o), 0);
        chk("reset cnt", int'(bus.err_cnt_o), 0);

        // Clean PRBS7 lock.
        seed_gen();
        cur_mode = 2'd0;
        good_words(18);
        chk("t1 lock", int'(bus.lock_o), 1);
        chk("t1 cnt", int'(bus.err_cnt_o), 0);

        // Single bit flip at bit 3: errors at bit 3 and at bits 1,2 of the next word.
        gen_word(w);
        tick(1'b1, w ^ 8'h08, 1'b0);
        pulses = int'(bus.err_o);
        for (int i = 0; i < 3; i++) begin
            good_words(1);
            pulses += int'(bus.err_o);
        end
        chk("t2 pulses", pulses, 2);
        chk("t2 cnt", int'(bus.err_cnt_o), 3);
        chk("t2 lock", int'(bus.lock_o), 1);

        // Four inverted words force HUNT, then relock.
        for (int i = 0; i < 4; i++) begin
            if (i == 3) chk("t3 lock before 4th", int'(bus.lock_o), 1);
            gen_word(w);
            tick(1'b1, ~w, 1'b0);
        end
        chk("t3 unlock", int'(bus.lock_o), 0);
        good_words(18);
        chk("t3 relock", int'(bus.lock_o), 1);

        // Randomised traffic: gaps, flips, bursts, clears and mode changes.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) cur_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                tick(1'b0, W'($urandom), 1'($urandom_range(0, 19) == 0));
            end else begin
                gen_word(w);
                if ($urandom_range(0, 11) == 0) w ^= W'(1 << $urandom_range(0, W-1));
                if ($urandom_range(0, 59) == 0) w = ~w;
                tick(1'b1, w, 1'($urandom_range(0, 49) == 0));
            end
        end

        // Saturation with a 4-bit counter, then clear colliding with a flip.
        cur_mode = 2'd0;
        good_words(20);
        chk("t5 lock", int'(bus.lock_o), 1);
        gen_word(w);
        tick(1'b1, w, 1'b1);
        chk("t5 clr", int'(bus.err_cnt_o), 0);
        for (int f = 1; f <= 6; f++) begin
            gen_word(w);
            tick(1'b1, w ^ 8'h04, 1'b0);
            good_words(7);
            chk("t5 sat", int'(bus.err_cnt_o), (3 * f > 15) ? 15 : 3 * f);
        end
        gen_word(w);
        tick(1'b1, w ^ 8'h04, 1'b1);
        chk("t5 clr wins", int'(bus.err_cnt_o), 0);
        chk("t5 lock kept", int'(bus.lock_o), 1);
        good_words(4);

        // All-zero input never locks in any mode.
        do_reset();
        seen_lock = 0;
        for (int m = 0; m < 4; m++) begin
            cur_mode = 2'(m);
            for (int i = 0; i < 1000; i++) begin
                tick(1'b1, '0, 1'b0);
                seen_lock |= int'(bus.lock_o);
            end
            chk("t4 cnt", int'(bus.err_cnt_o), 0);
        end
        chk("t4 never locked", seen_lock, 0);

        // Mode switch PRBS7 -> PRBS31 keeps the count and relocks.
        do_reset();
        seed_gen();
        cur_mode = 2'd0;
        good_words(18);
        chk("t6 lock7", int'(bus.lock_o), 1);
        gen_word(w);
        tick(1'b1, w ^ 8'h08, 1'b0);
        good_words(3);
        chk("t6 cnt", int'(bus.err_cnt_o), 3);
        cur_mode = 2'd3;
        good_words(1);
        chk("t6 unlock", int'(bus.lock_o), 0);
        chk("t6 cnt held", int'(bus.err_cnt_o), 3);
        good_words(18);
        chk("t6 relock31", int'(bus.lock_o), 1);
        chk("t6 cnt after", int'(bus.err_cnt_o), 3);
        good_words(3);

        // Asynchronous reset in mid-cycle clears outputs at once.
        #3;
        rstn_i = 1'b0;
        model_reset();
        #1;
        chk("async lock", int'(bus.lock_o), 0);
        chk("async err", int'(bus.err_o), 0);
        chk("async cnt", int'(bus.err_cnt_o), 0);
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        good_words(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
